// File: rtl/comma_aligner_10b.sv
// Serial-to-10b deserialiser that aligns on K28.5 commas and tracks lock.
// Optional: define ALIGN_ERR_CNT_EN to add a saturating misaligned-comma counter.
module comma_aligner_10b #(
   parameter int LOCK_COMMAS = 4,
   parameter int LOSS_COMMAS = 2
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       serial_in,
   output logic [9:0] out_10b,
   output logic       valid_out,
   output logic       is_comma,
   output logic       locked
`ifdef ALIGN_ERR_CNT_EN
   ,
   output logic [7:0] align_err_cnt
`endif
);

   localparam int GW = $clog2(LOCK_COMMAS + 1);
   localparam int MW = $clog2(LOSS_COMMAS + 1);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_COMMAS);
   localparam logic [MW-1:0] LOSS_V = MW'(LOSS_COMMAS);

   typedef enum logic [1:0] {HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2} state_t;

   state_t        state;
   logic [8:0]    sr;
   logic [3:0]    bit_cnt;
   logic [GW-1:0] good_cnt;
   logic [MW-1:0] miss_cnt;
   logic [9:0]    w;
   logic          comma_hit;
   logic          boundary;
   logic [GW-1:0] good_nxt;
   logic [MW-1:0] miss_nxt;

   // The window includes the bit arriving this cycle, so a symbol is captured
   // on the same edge that shifts in its last bit.
   assign w         = {sr, serial_in};
   assign comma_hit = (w == 10'b0011111010) || (w == 10'b1100000101);
   assign boundary  = (state != HUNT) && (bit_cnt == 4'd9);
   assign good_nxt  = good_cnt + GW'(1);
   assign miss_nxt  = miss_cnt + MW'(1);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= HUNT;
         sr        <= '0;
         bit_cnt   <= '0;
         good_cnt  <= '0;
         miss_cnt  <= '0;
         out_10b   <= '0;
         valid_out <= 1'b0;
         is_comma  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         sr        <= w[8:0];
         valid_out <= 1'b0;
         is_comma  <= 1'b0;
         case (state)
            HUNT: begin
               if (comma_hit) begin
                  out_10b   <= w;
                  valid_out <= 1'b1;
                  is_comma  <= 1'b1;
                  bit_cnt   <= '0;
                  good_cnt  <= GW'(1);
                  miss_cnt  <= '0;
                  if (LOCK_COMMAS == 1) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end else begin
                     state  <= CONFIRM;
                  end
               end
            end
            CONFIRM: begin
               if (boundary) begin
                  bit_cnt   <= '0;
                  out_10b   <= w;
                  valid_out <= 1'b1;
                  is_comma  <= comma_hit;
                  if (comma_hit) begin
                     good_cnt <= good_nxt;
                     if (good_nxt == LOCK_V) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end
               end else if (comma_hit) begin
                  // Comma on a new phase: restart confirmation from it.
                  out_10b   <= w;
                  valid_out <= 1'b1;
                  is_comma  <= 1'b1;
                  bit_cnt   <= '0;
                  good_cnt  <= GW'(1);
               end else begin
                  bit_cnt   <= bit_cnt + 4'd1;
               end
            end
            LOCKED: begin
               if (boundary) begin
                  bit_cnt   <= '0;
                  out_10b   <= w;
                  valid_out <= 1'b1;
                  is_comma  <= comma_hit;
                  if (comma_hit)
                     miss_cnt <= '0;
               end else if (comma_hit) begin
                  if (miss_nxt == LOSS_V) begin
                     state    <= HUNT;
                     locked   <= 1'b0;
                     miss_cnt <= '0;
                     good_cnt <= '0;
                     bit_cnt  <= '0;
                  end else begin
                     miss_cnt <= miss_nxt;
                     bit_cnt  <= bit_cnt + 4'd1;
                  end
               end else begin
                  bit_cnt   <= bit_cnt + 4'd1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

`ifdef ALIGN_ERR_CNT_EN
   logic misalign;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign misalign = comma_hit && (state != HUNT) && !boundary;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         align_err_cnt <= '0;
      else if (misalign)
         align_err_cnt <= sat_inc8(align_err_cnt);
   end
`endif

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Directed bench for comma_aligner_10b: reset, acquisition, passthrough,
// re-alignment, loss of lock and (with ALIGN_ERR_CNT_EN) the error counter.
module tb_comma_aligner_10b;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       serial_in;
   logic [9:0] out_10b;
   logic       valid_out;
   logic       is_comma;
   logic       locked;
`ifdef ALIGN_ERR_CNT_EN
   logic [7:0] align_err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int vcount = 0;

   localparam logic [9:0] KM   = 10'h0FA;  // K28.5- 0011111010
   localparam logic [9:0] KP   = 10'h305;  // K28.5+ 1100000101
   localparam logic [9:0] D215 = 10'h2AA;  // D21.5  1010101010

   always #5 clk = ~clk;

   comma_aligner_10b dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .serial_in (serial_in),
      .out_10b   (out_10b),
      .valid_out (valid_out),
      .is_comma  (is_comma),
      .locked    (locked)
`ifdef ALIGN_ERR_CNT_EN
      ,
      .align_err_cnt (align_err_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      serial_in = b;
      @(posedge clk);
      #1;
      if (valid_out === 1'b1) vcount++;
   endtask

   task automatic send_sym(input logic [9:0] s);
      vcount = 0;
      for (int i = 9; i >= 0; i--) send_bit(s[i]);
   endtask

   task automatic chk_sym(input string tag, input logic v, input logic [9:0] o,
                          input logic c, input logic l);
      check({tag, "_valid"}, valid_out, v);
      check({tag, "_out"}, out_10b, o);
      check({tag, "_comma"}, is_comma, c);
      check({tag, "_locked"}, locked, l);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      reset_L   = 1'b0;
      serial_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         serial_in = i[0];
         @(posedge clk);
         #1;
      end
      chk_sym("reset", 1'b0, 10'h000, 1'b0, 1'b0);
      reset_L = 1'b1;

      // Three leading bits, then four K28.5- : first strobe on the 13th bit
      vcount = 0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("hunt_no_strobe", vcount, 0);
      check("hunt_locked", locked, 1'b0);
      for (int k = 0; k < 4; k++) begin
         send_sym(KM);
         chk_sym("acq", 1'b1, KM, 1'b1, (k == 3));
         check("acq_strobes", vcount, 1);
      end

      for (int k = 0; k < 2; k++) begin
         send_sym(KP);
         chk_sym("pass_kp", 1'b1, KP, 1'b1, 1'b1);
         send_sym(D215);
         chk_sym("pass_d215", 1'b1, D215, 1'b0, 1'b1);
      end

      // Three slip bits: commas now end 3 bits past the locked boundary
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_sym(KP);
      chk_sym("loss_miss1", 1'b0, 10'h2E0, 1'b0, 1'b1);
      send_sym(KP);
      chk_sym("loss_miss2", 1'b0, 10'h2E0, 1'b0, 1'b0);
      send_sym(KP);
      chk_sym("rehunt", 1'b1, KP, 1'b1, 1'b0);

      send_sym(KP);
      chk_sym("confirm2", 1'b1, KP, 1'b1, 1'b0);
      send_bit(1'b1);
      send_sym(KP);
      chk_sym("realign", 1'b1, KP, 1'b1, 1'b0);
      check("realign_strobes", vcount, 2);
      for (int k = 0; k < 3; k++) begin
         send_sym(KP);
         chk_sym("newphase", 1'b1, KP, 1'b1, (k == 2));
      end

`ifdef ALIGN_ERR_CNT_EN
      check("err_before", align_err_cnt, 3);
      for (int k = 0; k < 10; k++) begin
         send_bit(1'b1);
         send_sym(KP);
      end
      check("err_mid", align_err_cnt, 12);
      for (int k = 0; k < 290; k++) begin
         send_bit(1'b1);
         send_sym(KP);
      end
      check("err_sat", align_err_cnt, 255);
`endif

      // Asynchronous reset in the middle of a symbol
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      reset_L = 1'b0;
      #2;
      chk_sym("midreset", 1'b0, 10'h000, 1'b0, 1'b0);
`ifdef ALIGN_ERR_CNT_EN
      check("err_reset", align_err_cnt, 0);
`endif
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      vcount = 0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("post_reset_no_strobe", vcount, 0);
      send_sym(KM);
      chk_sym("post_reset_acq", 1'b1, KM, 1'b1, 1'b0);
      check("post_reset_strobes", vcount, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
